// File: rtl/imem_loader.sv
// imem_loader: boot-time writer that streams a framed, checksummed byte image
// into instruction memory as little-endian words, holding the core in reset until done.
module imem_loader #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error
);
    localparam int IW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {HDR, DATA, CSUM, DONE, ERR} state_t;

    state_t          state_q;
    logic [31:0]     cnt_q;
    logic [1:0]      bcnt_q;
    logic [IW-1:0]   idx_q;
    logic [7:0]      sum_q;
    logic [23:0]     asm_q;
    logic            acc;
    logic            last_byte;
    logic            last_word;
    logic [31:0]     cnt_d;
    logic [31:0]     word_d;
    logic [7:0]      sum_d;

    // Bytes enter at the top and shift down, so the first byte ends up least significant.
    assign acc       = in_valid & in_ready;
    assign cnt_d     = {in_data, cnt_q[31:8]};
    assign word_d    = {in_data, asm_q};
    assign sum_d     = sum_q + in_data;
    assign last_byte = bcnt_q == 2'd3;
    assign last_word = 32'(idx_q) == cnt_q - 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= HDR;
            cnt_q    <= '0;
            bcnt_q   <= '0;
            idx_q    <= '0;
            sum_q    <= '0;
            asm_q    <= '0;
            in_ready <= 1'b0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            core_rst <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            we <= 1'b0;
            case (state_q)
                HDR: begin
                    in_ready <= 1'b1;
                    if (acc) begin
                        cnt_q  <= cnt_d;
                        sum_q  <= sum_d;
                        bcnt_q <= bcnt_q + 2'd1;
                        if (last_byte) begin
                            if (cnt_d > 32'(DEPTH)) begin
                                state_q  <= ERR;
                                error    <= 1'b1;
                                in_ready <= 1'b0;
                            end else begin
                                state_q <= (cnt_d == 32'd0) ? CSUM : DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (acc) begin
                        asm_q  <= word_d[31:8];
                        sum_q  <= sum_d;
                        bcnt_q <= bcnt_q + 2'd1;
                        if (last_byte) begin
                            we    <= 1'b1;
                            waddr <= BASE_ADDR + (32'(idx_q) << 2);
                            wdata <= word_d;
                            idx_q <= idx_q + IW'(1);
                            if (last_word) state_q <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (acc) begin
                        in_ready <= 1'b0;
                        if (in_data == sum_q) begin
                            state_q  <= DONE;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else begin
                            state_q <= ERR;
                            error   <= 1'b1;
                        end
                    end
                end
                default: in_ready <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven directed checks of the instruction-memory loader,
// plus hand-written stall and mid-frame reset sequences.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [31:0] a;
        logic [31:0] w;
        logic        dn;
        logic        er;
        logic        cr;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    imem_loader #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .core_rst(core_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst && we) begin
        wa.push_back(waddr);
        wd.push_back(wdata);
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    function automatic void add(logic v, logic [7:0] d, logic rdy, logic w_e, logic [31:0] a,
                                logic [31:0] w, logic dn, logic er, logic cr);
        vec_t t;
        t.v = v; t.d = d; t.rdy = rdy; t.we = w_e; t.a = a; t.w = w;
        t.dn = dn; t.er = er; t.cr = cr;
        tbl.push_back(t);
    endfunction

    // Nominal two-word frame with a chosen checksum byte; good selects the expected outcome.
    function automatic void build_frame(logic [7:0] cs, bit good);
        logic [7:0] b[13];
        b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h50, 8'h00, cs};
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 13; i++)
            add(1, b[i], 1, (i == 8) || (i == 12), (i == 12) ? 32'h4 : 32'h0,
                (i == 12) ? 32'h0050_0093 : 32'h0000_0013, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, good, !good, !good);
        add(0, 8'h00, 0, 0, 0, 0, good, !good, !good);
    endfunction

    // Starts and ends on a falling edge: check outputs, then drive the next inputs.
    task automatic play(input string name);
        foreach (tbl[i]) begin
            chk($sformatf("%s[%0d] in_ready", name, i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("%s[%0d] we", name, i), 32'(we), 32'(tbl[i].we));
            chk($sformatf("%s[%0d] done", name, i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("%s[%0d] error", name, i), 32'(error), 32'(tbl[i].er));
            chk($sformatf("%s[%0d] core_rst", name, i), 32'(core_rst), 32'(tbl[i].cr));
            if (tbl[i].we) begin
                chk($sformatf("%s[%0d] waddr", name, i), waddr, tbl[i].a);
                chk($sformatf("%s[%0d] wdata", name, i), wdata, tbl[i].w);
            end
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            @(negedge clk);
        end
        tbl.delete();
    endtask

    task automatic check_reset_state(input string name);
        chk({name, " in_ready"}, 32'(in_ready), 0);
        chk({name, " we"}, 32'(we), 0);
        chk({name, " waddr"}, waddr, 0);
        chk({name, " wdata"}, wdata, 0);
        chk({name, " done"}, 32'(done), 0);
        chk({name, " error"}, 32'(error), 0);
        chk({name, " core_rst"}, 32'(core_rst), 1);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1 check_reset_state(name);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] fr[14];
        fr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h50, 8'h00, 8'hF8, 8'h00};

        do_reset("reset");
        build_frame(8'hF8, 1);
        play("nominal");

        do_reset("reset2");
        build_frame(8'hF7, 0);
        play("badsum");

        do_reset("reset3");
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
        add(1, 8'h01, 1, 0, 0, 0, 0, 0, 1);
        add(1, 8'h04, 1, 0, 0, 0, 0, 0, 1);
        add(1, 8'h00, 1, 0, 0, 0, 0, 0, 1);
        add(1, 8'h00, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) add(1, 8'hAA, 0, 0, 0, 0, 0, 1, 1);
        add(0, 8'h00, 0, 0, 0, 0, 0, 1, 1);
        play("oversize");

        do_reset("reset4");
        wa.delete(); wd.delete();
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) add(1, 8'h00, 1, 0, 0, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 1, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0, 1, 0, 0);
        play("empty");
        chk("empty write count", wa.size(), 0);

        do_reset("reset5");
        wa.delete(); wd.delete();
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(fr[i]);
        end
        repeat (3) @(negedge clk);
        chk("stall done", 32'(done), 1);
        chk("stall error", 32'(error), 0);
        chk("stall core_rst", 32'(core_rst), 0);
        chk("stall in_ready", 32'(in_ready), 0);
        chk("stall write count", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("stall waddr0", wa[0], 32'h0);
            chk("stall wdata0", wd[0], 32'h0000_0013);
            chk("stall waddr1", wa[1], 32'h4);
            chk("stall wdata1", wd[1], 32'h0050_0093);
        end

        do_reset("reset6");
        @(negedge clk);
        for (int i = 0; i < 8; i++) send_byte(fr[i]);
        chk("inflight we", 32'(we), 1);
        rst = 1'b0;
        #1 check_reset_state("inflight reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) send_byte(fr[i]);
        rst = 1'b0;
        #1 check_reset_state("midframe reset");
        @(negedge clk);
        rst = 1'b1;
        build_frame(8'hF8, 1);
        play("replay");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
